// File: rtl/image_store.sv
// rtl/image_store.sv - two-bank 64x64 frame store with load, ping-pong processing and raster dump
// Read bank holds the current image; processor writes build the next image in the other bank.
module image_store #(
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_valid,
  input  logic [PIX_W-1:0] load_data,
  output logic             load_ready,
  input  logic [5:0]       row,
  input  logic [5:0]       col,
  output logic [PIX_W-1:0] in_pix,
  input  logic             out_we,
  input  logic [PIX_W-1:0] out_pix,
  input  logic             mirror_done,
  input  logic             gray_done,
  input  logic             filter_done,
  output logic             dump_valid,
  output logic [PIX_W-1:0] dump_data,
  input  logic             dump_ready,
  output logic [1:0]       stage,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

  state_t           state;
  logic             bank_sel;
  logic [11:0]      ptr;
  logic             mirror_q, gray_q, filter_q;
  logic [PIX_W-1:0] bank0 [4096];
  logic [PIX_W-1:0] bank1 [4096];

  logic [11:0]      pix_addr;
  logic             load_xfer, dump_xfer, run_we, stage_rise;
  logic             wr_en, wr_hi;
  logic [11:0]      wr_addr;
  logic [PIX_W-1:0] wr_data;

  assign pix_addr  = {row, col};
  assign load_xfer = load_valid & load_ready;
  assign dump_xfer = dump_valid & dump_ready;
  assign run_we    = (state == RUN) & out_we;

  assign in_pix    = bank_sel ? bank1[pix_addr] : bank0[pix_addr];
  assign dump_data = bank_sel ? bank1[ptr] : bank0[ptr];

  // Only the done flag belonging to the current stage may advance processing.
  always_comb begin
    stage_rise = 1'b0;
    if (state == RUN) begin
      case (stage)
        2'd0:    stage_rise = mirror_done & ~mirror_q;
        2'd1:    stage_rise = gray_done & ~gray_q;
        2'd2:    stage_rise = filter_done & ~filter_q;
        default: stage_rise = 1'b0;
      endcase
    end
  end

  // Loader fills the read bank; processor writes target the other bank.
  always_comb begin
    wr_en   = load_xfer | run_we;
    wr_hi   = load_xfer ? bank_sel : ~bank_sel;
    wr_addr = load_xfer ? ptr : pix_addr;
    wr_data = load_xfer ? load_data : out_pix;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_hi) bank0[wr_addr] <= wr_data;
    if (wr_en && wr_hi)  bank1[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank_sel   <= 1'b0;
      ptr        <= 12'd0;
      stage      <= 2'd0;
      mirror_q   <= 1'b0;
      gray_q     <= 1'b0;
      filter_q   <= 1'b0;
      load_ready <= 1'b0;
      dump_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mirror_q   <= mirror_done;
      gray_q     <= gray_done;
      filter_q   <= filter_done;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            ptr        <= 12'd0;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_xfer) begin
            ptr <= ptr + 12'd1;
            if (ptr == 12'd4095) begin
              state      <= RUN;
              stage      <= 2'd0;
              load_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (stage_rise) begin
            bank_sel <= ~bank_sel;
            stage    <= stage + 2'd1;
            if (stage == 2'd2) begin
              state      <= DUMP;
              ptr        <= 12'd0;
              dump_valid <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (dump_xfer) begin
            ptr <= ptr + 12'd1;
            if (ptr == 12'd4095) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_store.sv
// tb/tb_image_store.sv - randomized bench for image_store against an image-level reference model
// Model keeps two whole images and which one is visible; a negedge process compares every cycle.
module tb_image_store;

  logic        clk = 1'b0;
  logic        rst_n, start, load_valid, load_ready, out_we;
  logic        mirror_done, gray_done, filter_done, dump_valid, dump_ready, frame_done;
  logic [23:0] load_data, in_pix, out_pix, dump_data;
  logic [5:0]  row, col;
  logic [1:0]  stage;

  int total = 0;
  int bad = 0;

  image_store #(.PIX_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .row(row), .col(col), .in_pix(in_pix), .out_we(out_we),
    .out_pix(out_pix), .mirror_done(mirror_done), .gray_done(gray_done),
    .filter_done(filter_done), .dump_valid(dump_valid), .dump_data(dump_data),
    .dump_ready(dump_ready), .stage(stage), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 loading, 2 processing, 3 dumping.
  logic [23:0] img   [2][4096];
  bit          known [2][4096];
  int          m_mode = 0;
  int          m_idx  = 0;
  int          m_stg  = 0;
  bit          m_rd   = 0;
  bit          m_fd   = 0;
  bit          pm = 0, pg = 0, pf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_idx <= 0; m_stg <= 0; m_rd <= 0; m_fd <= 0;
      pm <= 0; pg <= 0; pf <= 0;
    end else begin
      m_fd <= 0;
      pm <= mirror_done; pg <= gray_done; pf <= filter_done;
      case (m_mode)
        0: if (start) begin m_mode <= 1; m_idx <= 0; end
        1: if (load_valid) begin
          img[m_rd][m_idx]   <= load_data;
          known[m_rd][m_idx] <= 1;
          if (m_idx == 4095) begin m_mode <= 2; m_stg <= 0; m_idx <= 0; end
          else m_idx <= m_idx + 1;
        end
        2: begin
          if (out_we) begin
            img[!m_rd][{row, col}]   <= out_pix;
            known[!m_rd][{row, col}] <= 1;
          end
          if ((m_stg == 0 && mirror_done && !pm) || (m_stg == 1 && gray_done && !pg) ||
              (m_stg == 2 && filter_done && !pf)) begin
            m_rd  <= !m_rd;
            m_stg <= m_stg + 1;
            if (m_stg == 2) begin m_mode <= 3; m_idx <= 0; end
          end
        end
        default: if (dump_ready) begin
          if (m_idx == 4095) begin m_mode <= 0; m_idx <= 0; m_fd <= 1; end
          else m_idx <= m_idx + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("load_ready", load_ready, m_mode == 1);
      chk("dump_valid", dump_valid, m_mode == 3);
      chk("stage", stage, m_stg);
      chk("frame_done", frame_done, m_fd);
      if (known[m_rd][{row, col}]) chk("in_pix", in_pix, img[m_rd][{row, col}]);
      if (m_mode == 3 && known[m_rd][m_idx]) chk("dump_data", dump_data, img[m_rd][m_idx]);
    end
  end

  function automatic logic [23:0] fimg(input int i);
    logic [11:0] a;
    a = i[11:0];
    return {a, ~a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic random_proc(input int n);
    for (int k = 0; k < n; k++) begin
      row = 6'($urandom_range(0, 63));
      col = 6'($urandom_range(0, 63));
      out_we = 1'($urandom_range(0, 1));
      out_pix = 24'($urandom);
      tick();
    end
    out_we = 0;
  endtask

  task automatic load_frame(input logic [23:0] base, input bit rnd, input int stop_at, output int n);
    int guard;
    bit v, r;
    n = 0;
    guard = 0;
    while (load_ready && n < stop_at && guard < 20000) begin
      load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data = base + 24'(n);
      out_we = rnd;
      row = 6'($urandom_range(0, 63));
      col = 6'($urandom_range(0, 63));
      out_pix = 24'($urandom);
      v = load_valid;
      r = load_ready;
      tick();
      guard++;
      if (v && r) n++;
    end
    load_valid = 0;
    out_we = 0;
  endtask

  task automatic dump_frame(input bit toggle, input bit lit);
    int cnt, guard;
    bit rdy, held_ok;
    logic [23:0] held;
    cnt = 0; guard = 0; rdy = 0; held_ok = 0; held = '0;
    while (dump_valid && guard < 20000) begin
      rdy = toggle ? !rdy : 1'($urandom_range(0, 1));
      dump_ready = rdy;
      out_we = 1;
      row = 6'($urandom_range(0, 63));
      col = 6'($urandom_range(0, 63));
      out_pix = 24'($urandom);
      if (held_ok) chk("dump_stable", dump_data, held);
      if (rdy && lit) chk("dump_pix", dump_data, fimg(cnt));
      held = dump_data;
      held_ok = !rdy;
      tick();
      guard++;
      if (rdy) cnt++;
    end
    dump_ready = 0;
    out_we = 0;
    chk("dump_count", cnt, 4096);
    chk("frame_done_pulse", frame_done, 1);
    chk("idle_dump_valid", dump_valid, 0);
    tick();
    chk("frame_done_end", frame_done, 0);
    chk("idle_load_ready", load_ready, 0);
  endtask

  initial begin
    int n;
    rst_n = 0; start = 0; load_valid = 0; load_data = 0; out_we = 0; out_pix = 0;
    row = 0; col = 0; mirror_done = 0; gray_done = 0; filter_done = 0; dump_ready = 0;
    repeat (3) tick();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_stage", stage, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1;
    tick();

    // Frame 1: raster load i = i, staged processing, toggled dump
    start = 1; tick(); start = 0;
    load_frame(24'd0, 0, 5000, n);
    chk("load_count", n, 4096);
    chk("run_stage", stage, 0);
    row = 1; col = 2; #1;
    chk("pix_1_2", in_pix, 66);
    row = 5; col = 7; #1;
    chk("pix_5_7", in_pix, 327);
    gray_done = 1; tick(); tick();
    chk("gray_early_stage", stage, 0);
    chk("gray_early_pix", in_pix, 327);
    gray_done = 0; tick();
    out_we = 1; out_pix = 24'hABCDEF; tick(); out_we = 0;
    chk("write_hidden", in_pix, 327);
    mirror_done = 1; gray_done = 1; tick();
    chk("mirror_stage", stage, 1);
    chk("mirror_pix", in_pix, 24'hABCDEF);
    tick();
    chk("single_swap", stage, 1);
    mirror_done = 0; gray_done = 0;
    random_proc(300);
    filter_done = 1; tick();
    chk("filter_early", stage, 1);
    filter_done = 0; tick();
    gray_done = 1; tick();
    chk("gray_stage", stage, 2);
    gray_done = 0;
    for (int i = 0; i < 4096; i++) begin
      row = 6'(i >> 6); col = 6'(i & 63);
      out_we = 1; out_pix = fimg(i);
      tick();
    end
    out_we = 0;
    filter_done = 1; tick(); filter_done = 0;
    chk("dump_entry", dump_valid, 1);
    chk("dump_stage", stage, 3);
    dump_frame(1, 1);

    // Frame 2: abandoned by reset at pixel 2000, then a fresh randomized frame
    start = 1; tick(); start = 0;
    load_frame(24'h200000, 1, 2000, n);
    chk("abort_count", n, 2000);
    rst_n = 0; #1;
    chk("abort_load_ready", load_ready, 0);
    chk("abort_stage", stage, 0);
    tick(); rst_n = 1; tick();
    start = 1; tick(); start = 0;
    load_frame(24'h100000, 1, 5000, n);
    chk("reload_count", n, 4096);
    row = 0; col = 0; #1;
    chk("reload_first", in_pix, 24'h100000);
    row = 63; col = 63; #1;
    chk("reload_last", in_pix, 24'h100FFF);
    random_proc(100);
    start = 1; tick(); start = 0;
    random_proc(100);
    mirror_done = 1; tick(); mirror_done = 0;
    random_proc(200);
    gray_done = 1; tick(); gray_done = 0;
    random_proc(200);
    filter_done = 1; tick(); filter_done = 0;
    dump_frame(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_store.md
IMAGE_STORE -- requirements
Module: image_store

Interface
REQ-001 The block SHALL have parameter PIX_W, default 24, meaning pixel width (R [23:16], G [15:8], B [7:0]).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-005 The block SHALL have port load_valid  input  1  loader has a pixel.
REQ-006 The block SHALL have port load_data  input  PIX_W  loader pixel, raster order.
REQ-007 The block SHALL have port load_ready  output  1  store accepts a loader pixel.
REQ-008 The block SHALL have port row  input  6  processor-selected row.
REQ-009 The block SHALL have port col  input  6  processor-selected column.
REQ-010 The block SHALL have port in_pix  output  PIX_W  read-bank pixel at [row,col].
REQ-011 The block SHALL have port out_we  input  1  processor write enable.
REQ-012 The block SHALL have port out_pix  input  PIX_W  processor write data for [row,col].
REQ-013 The block SHALL have ports mirror_done, gray_done, filter_done  input  1 each  level stage-complete flags.
REQ-014 The block SHALL have port dump_valid  output  1  dump pixel available.
REQ-015 The block SHALL have port dump_data  output  PIX_W  dump pixel, raster order.
REQ-016 The block SHALL have port dump_ready  input  1  consumer accepts dump pixel.
REQ-017 The block SHALL have port stage  output  2  0 none, 1 mirrored, 2 gray, 3 filtered.
REQ-018 The block SHALL have port frame_done  output  1  one-cycle pulse after the last dump transfer.

Function
REQ-019 Storage SHALL be two 64x64xPIX_W banks; bank_sel register selects the read bank, the other bank is the write bank; address = {row,col}, row-major.
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, DUMP; IDLE->LOAD on start=1; start is ignored outside IDLE.
REQ-021 In LOAD: load_ready=1; on load_valid&load_ready the read bank at 12-bit pointer ptr SHALL be written with load_data and ptr increments; the transfer at ptr=4095 SHALL wrap ptr to 0 and move to RUN with stage=0.
REQ-022 in_pix SHALL be a combinational read of the read bank at {row,col}, valid in the same cycle row/col change, in every state.
REQ-023 In RUN, out_we=1 at a rising edge SHALL write out_pix to the write bank at {row,col}; out_we outside RUN SHALL be ignored.
REQ-024 Done flags SHALL be registered each cycle; a rising edge is flag=1 with previous sample 0.
REQ-025 In RUN, only the rise matching the stage SHALL count: mirror_done at stage 0, gray_done at stage 1, filter_done at stage 2; other rises SHALL be ignored.
REQ-026 A counted rise SHALL, at that same edge, toggle bank_sel and increment stage, so the next cycle reads the just-written image; at most one swap per cycle even if several flags rise together.
REQ-027 The counted filter_done rise SHALL move RUN->DUMP with ptr=0.
REQ-028 In DUMP: dump_valid=1, dump_data = read bank at ptr (combinational, stable while stalled); on dump_valid&dump_ready ptr increments; the transfer at ptr=4095 SHALL return to IDLE, wrap ptr to 0 and pulse frame_done for one cycle.
REQ-029 load_ready SHALL be 0 outside LOAD; dump_valid SHALL be 0 outside DUMP.
REQ-030 A write to [row,col] and a read of [row,col] in the same cycle access different banks; in_pix SHALL not reflect the write.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, bank_sel 0, ptr 0, stage 0, done samples 0, load_ready 0, dump_valid 0, frame_done 0.
REQ-032 Bank contents SHALL not be reset; in_pix/dump_data have no reset value.
REQ-033 Reset mid-LOAD, mid-RUN or mid-DUMP SHALL abandon the frame; the next start begins a fresh LOAD at ptr 0.

Verification
REQ-034 Load pixel i = i (0..4095) with load_valid held 1 -> load_ready 4096 cycles, RUN entered; row=1,col=2 -> in_pix=66.
REQ-035 In RUN, write out_pix=24'hABCDEF at [5,7], raise mirror_done -> next cycle stage=1, in_pix at [5,7]=24'hABCDEF; before rise in_pix at [5,7]=327.
REQ-036 Raise gray_done at stage 0 -> stage stays 0, no swap; then mirror_done and gray_done rise in the same cycle -> stage=1, exactly one swap.
REQ-037 Complete three stages, dump_ready toggled 1/0 each cycle -> 4096 transfers in raster order, dump_data stable while stalled, frame_done one cycle after last transfer, state IDLE.
REQ-038 Assert rst_n=0 at load pixel 2000 -> load_ready 0 immediately; start -> reload from ptr 0, first pixel lands at [0,0].
REQ-039 out_we=1 during LOAD and DUMP -> no bank change (dumped data equals the expected filtered image).
